// File: rtl/io_delay_tap_ctrl.sv
// IDELAY tap-load controller: writes CNTVALUEIN/LD on one of four channels,
// waits for the delay line to settle, then verifies CNTVALUEOUT and retries.
module io_delay_tap_ctrl #(
    parameter int SETTLE_CYC = 2,
    parameter int RETRY_MAX  = 3
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rdy,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic [1:0] req_ch,
    input  logic [4:0] req_tap,
    output logic       done,
    output logic       resp_err,
    output logic       ldcnt_01,
    output logic       ldcnt_02,
    output logic       ldcnt_03,
    output logic       ldcnt_04,
    output logic [4:0] dicnt_01,
    output logic [4:0] dicnt_02,
    output logic [4:0] dicnt_03,
    output logic [4:0] dicnt_04,
    input  logic [4:0] docnt_01,
    input  logic [4:0] docnt_02,
    input  logic [4:0] docnt_03,
    input  logic [4:0] docnt_04,
    output logic       busy
);

    typedef enum logic [2:0] {
        WAIT_RDY,
        IDLE,
        LOAD,
        SETTLE,
        CHECK
    } state_e;

    localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYC - 1);
    localparam logic [2:0] RETRY_LIM   = 3'(RETRY_MAX);

    state_e     state_q, state_d;
    logic       rdy_meta_q, rdy_s_q;
    logic [1:0] ch_q, ch_d;
    logic [4:0] tap_q, tap_d;
    logic [2:0] retry_q, retry_d;
    logic [3:0] settle_q, settle_d;
    logic [3:0] ldcnt_q, ldcnt_d;
    logic [4:0] dicnt_q [4];
    logic [4:0] dicnt_d [4];
    logic       done_q, done_d;
    logic       err_q, err_d;
    logic [4:0] docnt_arr [4];
    logic [4:0] docnt_sel;

    assign docnt_arr[0] = docnt_01;
    assign docnt_arr[1] = docnt_02;
    assign docnt_arr[2] = docnt_03;
    assign docnt_arr[3] = docnt_04;
    assign docnt_sel    = docnt_arr[ch_q];

    assign req_ready = (state_q == IDLE) && rdy_s_q;
    assign busy      = (state_q != IDLE);

    always_comb begin
        // NOTE: every signal written here gets a default first, so no path can infer a latch.
        state_d  = state_q;
        ch_d     = ch_q;
        tap_d    = tap_q;
        retry_d  = retry_q;
        settle_d = settle_q;
        ldcnt_d  = '0;
        dicnt_d  = dicnt_q;
        done_d   = 1'b0;
        err_d    = 1'b0;

        case (state_q)
            WAIT_RDY: begin
                if (rdy_s_q) state_d = IDLE;
            end
            IDLE: begin
                if (!rdy_s_q) begin
                    state_d = WAIT_RDY;
                end else if (req_valid) begin
                    ch_d             = req_ch;
                    tap_d            = req_tap;
                    retry_d          = '0;
                    dicnt_d[req_ch]  = req_tap;
                    ldcnt_d[req_ch]  = 1'b1;
                    state_d          = LOAD;
                end
            end
            LOAD: begin
                settle_d = '0;
                state_d  = SETTLE;
            end
            SETTLE: begin
                if (settle_q == SETTLE_LAST) state_d = CHECK;
                else                         settle_d = settle_q + 4'd1;
            end
            CHECK: begin
                if (docnt_sel == tap_q) begin
                    done_d  = 1'b1;
                    state_d = IDLE;
                end else if (retry_q < RETRY_LIM) begin
                    retry_d       = retry_q + 3'd1;
                    ldcnt_d[ch_q] = 1'b1;
                    state_d       = LOAD;
                end else begin
                    done_d  = 1'b1;
                    err_d   = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = WAIT_RDY;
        endcase

        // Losing the reference clock ready aborts the operation and overrides any CHECK verdict.
        if ((state_q inside {LOAD, SETTLE, CHECK}) && !rdy_s_q) begin
            state_d = WAIT_RDY;
            done_d  = 1'b1;
            err_d   = 1'b1;
            ldcnt_d = '0;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= WAIT_RDY;
            rdy_meta_q <= 1'b0;
            rdy_s_q    <= 1'b0;
            ch_q       <= '0;
            tap_q      <= '0;
            retry_q    <= '0;
            settle_q   <= '0;
            ldcnt_q    <= '0;
            // NOTE: the tap registers drive the pads directly, so this small array is reset too.
            dicnt_q    <= '{default: '0};
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            rdy_meta_q <= rdy;
            rdy_s_q    <= rdy_meta_q;
            ch_q       <= ch_d;
            tap_q      <= tap_d;
            retry_q    <= retry_d;
            settle_q   <= settle_d;
            ldcnt_q    <= ldcnt_d;
            dicnt_q    <= dicnt_d;
            done_q     <= done_d;
            err_q      <= err_d;
        end
    end

    assign done     = done_q;
    assign resp_err = err_q;
    assign ldcnt_01 = ldcnt_q[0];
    assign ldcnt_02 = ldcnt_q[1];
    assign ldcnt_03 = ldcnt_q[2];
    assign ldcnt_04 = ldcnt_q[3];
    assign dicnt_01 = dicnt_q[0];
    assign dicnt_02 = dicnt_q[1];
    assign dicnt_03 = dicnt_q[2];
    assign dicnt_04 = dicnt_q[3];

endmodule
